// File: rtl/mem_port_arbiter_if.sv
//------------------------------------------------------------------------------
// Module   : mem_port_arbiter_if
// Brief    : Request/response bundle of the IF and MEM stages plus the external
//            memory bus. "master" is the arbiter view and "slave" is the view of
//            the stages and the memory controller.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface mem_port_arbiter_if;
    logic        if_re;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_stall;
    logic        mem_re;
    logic [31:0] mem_read_addr;
    logic        mem_we;
    logic [31:0] mem_write_addr;
    logic [3:0]  mem_write;
    logic [31:0] mem_write_instr;
    logic [31:0] mem_rdata;
    logic        mem_stall;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_sel;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        bus_err;

    modport master (
        input  if_re, if_addr, mem_re, mem_read_addr, mem_we, mem_write_addr,
               mem_write, mem_write_instr, bus_rdata, bus_ack,
        output if_rdata, if_stall, mem_rdata, mem_stall, bus_req, bus_we,
               bus_addr, bus_sel, bus_wdata, bus_err
    );

    modport slave (
        output if_re, if_addr, mem_re, mem_read_addr, mem_we, mem_write_addr,
               mem_write, mem_write_instr, bus_rdata, bus_ack,
        input  if_rdata, if_stall, mem_rdata, mem_stall, bus_req, bus_we,
               bus_addr, bus_sel, bus_wdata, bus_err
    );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
//------------------------------------------------------------------------------
// Module   : mem_port_arbiter
// Brief    : Shares one external memory bus between IF and MEM (MEM has fixed
//            priority). Define MEM_ARB_TIMEOUT_EN to enable the ack watchdog.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  wire logic           clk,
    input  wire logic           rst,
    mem_port_arbiter_if.master  arb
);

    localparam logic [2:0]  c_IDLE         = 3'd0;
    localparam logic [2:0]  c_D_BUSY       = 3'd1;
    localparam logic [2:0]  c_I_BUSY       = 3'd2;
    localparam logic [2:0]  c_D_DONE       = 3'd3;
    localparam logic [2:0]  c_I_DONE       = 3'd4;
    localparam logic [31:0] c_TIMEOUT_DATA = 32'hDEAD_BEEF;

    generate
        if (TIMEOUT < 1 || TIMEOUT >= (1 << CNT_W)) begin : g_bad_timeout
            $error("mem_port_arbiter: TIMEOUT must be in 1 .. 2**CNT_W-1");
        end
    endgenerate

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;
    logic        w_mem_req;
    logic        w_timeout;
    logic        r_bus_req;
    logic        r_bus_we;
    logic [31:0] r_bus_addr;
    logic [3:0]  r_bus_sel;
    logic [31:0] r_bus_wdata;
    logic [31:0] r_if_rdata;
    logic [31:0] r_mem_rdata;

    assign w_mem_req = arb.mem_re | arb.mem_we;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] c_WDOG_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_wdog;
    logic             r_bus_err;
    logic             w_busy;

    assign w_busy    = (r_state == c_D_BUSY) || (r_state == c_I_BUSY);
    assign w_timeout = w_busy && !arb.bus_ack && (r_wdog == c_WDOG_LAST);

    // Counter idles at zero, so it starts fresh on every BUSY entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdog    <= '0;
            r_bus_err <= 1'b0;
        end else begin
            if (w_busy) r_wdog <= r_wdog + CNT_W'(1);
            else        r_wdog <= '0;
            if (w_timeout) r_bus_err <= 1'b1;
        end
    end

    assign arb.bus_err = r_bus_err;
`else
    assign w_timeout   = 1'b0;
    assign arb.bus_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_mem_req)      w_next_state = c_D_BUSY;
                else if (arb.if_re) w_next_state = c_I_BUSY;
            end
            c_D_BUSY: if (arb.bus_ack || w_timeout) w_next_state = c_D_DONE;
            c_I_BUSY: if (arb.bus_ack || w_timeout) w_next_state = c_I_DONE;
            default:  w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        arb.mem_stall = w_mem_req && (r_state != c_D_DONE);
        arb.if_stall  = arb.if_re && (r_state != c_I_DONE);
    end

    // Bus fields are only loaded in IDLE, so they stay frozen through BUSY.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_sel   <= '0;
            r_bus_wdata <= '0;
            r_if_rdata  <= '0;
            r_mem_rdata <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_mem_req) begin
                        r_bus_req <= 1'b1;
                        r_bus_we  <= arb.mem_we;
                        if (arb.mem_we) begin
                            r_bus_addr  <= arb.mem_write_addr;
                            r_bus_sel   <= arb.mem_write;
                            r_bus_wdata <= arb.mem_write_instr;
                        end else begin
                            r_bus_addr <= arb.mem_read_addr;
                            r_bus_sel  <= 4'b1111;
                        end
                    end else if (arb.if_re) begin
                        r_bus_req  <= 1'b1;
                        r_bus_we   <= 1'b0;
                        r_bus_addr <= arb.if_addr;
                        r_bus_sel  <= 4'b1111;
                    end
                end
                c_D_BUSY: begin
                    if (arb.bus_ack) begin
                        r_bus_req <= 1'b0;
                        if (!r_bus_we) r_mem_rdata <= arb.bus_rdata;
                    end else if (w_timeout) begin
                        r_bus_req   <= 1'b0;
                        r_mem_rdata <= c_TIMEOUT_DATA;
                    end
                end
                c_I_BUSY: begin
                    if (arb.bus_ack) begin
                        r_bus_req  <= 1'b0;
                        r_if_rdata <= arb.bus_rdata;
                    end else if (w_timeout) begin
                        r_bus_req  <= 1'b0;
                        r_if_rdata <= c_TIMEOUT_DATA;
                    end
                end
                default: ;
            endcase
        end
    end

    assign arb.bus_req   = r_bus_req;
    assign arb.bus_we    = r_bus_we;
    assign arb.bus_addr  = r_bus_addr;
    assign arb.bus_sel   = r_bus_sel;
    assign arb.bus_wdata = r_bus_wdata;
    assign arb.if_rdata  = r_if_rdata;
    assign arb.mem_rdata = r_mem_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_mem_port_arbiter
// Brief    : Directed self-checking bench for mem_port_arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mem_port_arbiter_if bif ();

    mem_port_arbiter #(
        .TIMEOUT (4),
        .CNT_W   (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .arb (bif)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst                  = 1'b1;
        bif.if_re            = 1'b0;
        bif.if_addr          = '0;
        bif.mem_re           = 1'b0;
        bif.mem_read_addr    = '0;
        bif.mem_we           = 1'b0;
        bif.mem_write_addr   = '0;
        bif.mem_write        = '0;
        bif.mem_write_instr  = '0;
        bif.bus_rdata        = '0;
        bif.bus_ack          = 1'b0;
        repeat (3) step();

        // Reset state
        check("rst_bus_req",   32'(bif.bus_req),   32'd0);
        check("rst_bus_we",    32'(bif.bus_we),    32'd0);
        check("rst_bus_addr",  bif.bus_addr,       32'd0);
        check("rst_bus_sel",   32'(bif.bus_sel),   32'd0);
        check("rst_bus_wdata", bif.bus_wdata,      32'd0);
        check("rst_if_rdata",  bif.if_rdata,       32'd0);
        check("rst_mem_rdata", bif.mem_rdata,      32'd0);
        check("rst_bus_err",   32'(bif.bus_err),   32'd0);
        check("rst_stalls",    {30'd0, bif.if_stall, bif.mem_stall}, 32'd0);
        rst = 1'b0;

        // 1: IF read 0x100, ack in third busy cycle
        bif.if_re   = 1'b1;
        bif.if_addr = 32'h0000_0100;
        #1 check("t1_stall_at_req", 32'(bif.if_stall), 32'd1);
        step();
        check("t1_bus_req",  32'(bif.bus_req), 32'd1);
        check("t1_bus_addr", bif.bus_addr,     32'h0000_0100);
        check("t1_bus_sel",  32'(bif.bus_sel), 32'hF);
        check("t1_bus_we",   32'(bif.bus_we),  32'd0);
        step();
        step();
        check("t1_stall_busy", 32'(bif.if_stall), 32'd1);
        bif.bus_ack   = 1'b1;
        bif.bus_rdata = 32'h2402_0005;
        step();
        bif.bus_ack   = 1'b0;
        bif.bus_rdata = '0;
        check("t1_stall_done", 32'(bif.if_stall), 32'd0);
        check("t1_if_rdata",   bif.if_rdata,      32'h2402_0005);
        check("t1_req_done",   32'(bif.bus_req),  32'd0);
        bif.if_re = 1'b0;
        step();
        check("t1_idle_req", 32'(bif.bus_req), 32'd0);

        // 2: MEM word write with simultaneous IF request
        bif.mem_we          = 1'b1;
        bif.mem_write_addr  = 32'h0000_0200;
        bif.mem_write       = 4'b1111;
        bif.mem_write_instr = 32'hCAFE_BABE;
        bif.if_re           = 1'b1;
        bif.if_addr         = 32'h0000_0104;
        step();
        check("t2_bus_we",     32'(bif.bus_we),    32'd1);
        check("t2_bus_addr",   bif.bus_addr,       32'h0000_0200);
        check("t2_bus_wdata",  bif.bus_wdata,      32'hCAFE_BABE);
        check("t2_bus_sel",    32'(bif.bus_sel),   32'hF);
        check("t2_mem_stall",  32'(bif.mem_stall), 32'd1);
        check("t2_if_stall",   32'(bif.if_stall),  32'd1);
        bif.bus_ack = 1'b1;
        step();
        bif.bus_ack = 1'b0;
        check("t2_mem_stall_done", 32'(bif.mem_stall), 32'd0);
        check("t2_if_stall_done",  32'(bif.if_stall),  32'd1);
        check("t2_req_done",       32'(bif.bus_req),   32'd0);
        bif.mem_we = 1'b0;
        step();
        check("t2_req_idle",   32'(bif.bus_req),  32'd0);
        check("t2_if_stall_i", 32'(bif.if_stall), 32'd1);
        step();
        check("t2_if_req",   32'(bif.bus_req), 32'd1);
        check("t2_if_addr",  bif.bus_addr,     32'h0000_0104);
        check("t2_if_we",    32'(bif.bus_we),  32'd0);
        check("t2_if_sel",   32'(bif.bus_sel), 32'hF);
        bif.bus_ack   = 1'b1;
        bif.bus_rdata = 32'h1111_2222;
        step();
        bif.bus_ack   = 1'b0;
        check("t2_if_rdata", bif.if_rdata,      32'h1111_2222);
        check("t2_if_done",  32'(bif.if_stall), 32'd0);
        bif.if_re = 1'b0;
        step();

        // MEM read to give mem_rdata a known non-zero value
        bif.mem_re        = 1'b1;
        bif.mem_read_addr = 32'h0000_0300;
        step();
        check("rd_bus_addr", bif.bus_addr,     32'h0000_0300);
        check("rd_bus_sel",  32'(bif.bus_sel), 32'hF);
        check("rd_bus_we",   32'(bif.bus_we),  32'd0);
        bif.bus_ack   = 1'b1;
        bif.bus_rdata = 32'h0BAD_F00D;
        step();
        bif.bus_ack   = 1'b0;
        check("rd_mem_rdata", bif.mem_rdata,      32'h0BAD_F00D);
        check("rd_mem_stall", 32'(bif.mem_stall), 32'd0);
        check("rd_if_hold",   bif.if_rdata,       32'h1111_2222);
        bif.mem_re = 1'b0;
        step();

        // 3: byte store to 0x203, lane 0
        bif.mem_we          = 1'b1;
        bif.mem_write_addr  = 32'h0000_0203;
        bif.mem_write       = 4'b0001;
        bif.mem_write_instr = 32'h5A5A_5A5A;
        step();
        check("t3_bus_sel",   32'(bif.bus_sel), 32'h1);
        check("t3_bus_addr",  bif.bus_addr,     32'h0000_0203);
        check("t3_bus_wdata", bif.bus_wdata,    32'h5A5A_5A5A);
        check("t3_bus_we",    32'(bif.bus_we),  32'd1);
        bif.bus_ack   = 1'b1;
        bif.bus_rdata = 32'hFFFF_FFFF;
        step();
        bif.bus_ack   = 1'b0;
        check("t3_mem_rdata", bif.mem_rdata,      32'h0BAD_F00D);
        check("t3_mem_stall", 32'(bif.mem_stall), 32'd0);
        bif.mem_we = 1'b0;
        step();

        // 4: reset during D_BUSY, then a late ack
        bif.mem_re        = 1'b1;
        bif.mem_read_addr = 32'h0000_0500;
        step();
        check("t4_busy_req", 32'(bif.bus_req), 32'd1);
        rst        = 1'b1;
        bif.mem_re = 1'b0;
        step();
        check("t4_rst_req",   32'(bif.bus_req),  32'd0);
        check("t4_rst_addr",  bif.bus_addr,      32'd0);
        check("t4_rst_sel",   32'(bif.bus_sel),  32'd0);
        check("t4_rst_we",    32'(bif.bus_we),   32'd0);
        check("t4_rst_wdata", bif.bus_wdata,     32'd0);
        check("t4_rst_mrd",   bif.mem_rdata,     32'd0);
        check("t4_rst_ird",   bif.if_rdata,      32'd0);
        rst           = 1'b0;
        bif.bus_ack   = 1'b1;
        bif.bus_rdata = 32'h1234_5678;
        step();
        bif.bus_ack   = 1'b0;
        check("t4_late_req",   32'(bif.bus_req),   32'd0);
        check("t4_late_mrd",   bif.mem_rdata,      32'd0);
        check("t4_late_ird",   bif.if_rdata,       32'd0);
        check("t4_late_stall", 32'(bif.mem_stall), 32'd0);
        step();
        check("t4_still_idle", 32'(bif.bus_req), 32'd0);

`ifdef MEM_ARB_TIMEOUT_EN
        // 5: watchdog abort after 4 busy cycles
        bif.mem_re        = 1'b1;
        bif.mem_read_addr = 32'h0000_0400;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("t5_busy_req%0d", i), 32'(bif.bus_req), 32'd1);
        end
        step();
        check("t5_to_req",   32'(bif.bus_req),   32'd0);
        check("t5_to_stall", 32'(bif.mem_stall), 32'd0);
        check("t5_to_data",  bif.mem_rdata,      32'hDEAD_BEEF);
        check("t5_to_err",   32'(bif.bus_err),   32'd1);
        bif.mem_re = 1'b0;
        step();
        bif.if_re   = 1'b1;
        bif.if_addr = 32'h0000_0108;
        step();
        bif.bus_ack   = 1'b1;
        bif.bus_rdata = 32'h0000_0077;
        step();
        bif.bus_ack = 1'b0;
        check("t5_if_rdata",  bif.if_rdata,     32'h0000_0077);
        check("t5_err_stuck", 32'(bif.bus_err), 32'd1);
        bif.if_re = 1'b0;
        step();
        rst = 1'b1;
        step();
        check("t5_err_rst", 32'(bif.bus_err), 32'd0);
        rst = 1'b0;
        step();
`else
        // 5: no watchdog, BUSY waits for the ack indefinitely
        bif.mem_re        = 1'b1;
        bif.mem_read_addr = 32'h0000_0400;
        repeat (10) step();
        check("t5_wait_req",   32'(bif.bus_req),   32'd1);
        check("t5_wait_stall", 32'(bif.mem_stall), 32'd1);
        check("t5_wait_err",   32'(bif.bus_err),   32'd0);
        bif.bus_ack   = 1'b1;
        bif.bus_rdata = 32'h600D_600D;
        step();
        bif.bus_ack = 1'b0;
        check("t5_late_data", bif.mem_rdata,    32'h600D_600D);
        check("t5_late_err",  32'(bif.bus_err), 32'd0);
        bif.mem_re = 1'b0;
        step();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
